multicycle_ctrl_fsm: RTL and testbench

//  Multicycle RV32 main control FSM; successor to the single-cycle main decoder. Sequences one instruction

---
 rtl/rv_ctrl_pkg.sv | 48 ++++
 rtl/multicycle_ctrl_fsm.sv | 216 +++++++++++++++++++++
 tb/tb_multicycle_ctrl_fsm.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32 main control FSM: opcodes,
// state enum and the datapath select codes driven by the controller.
package rv_ctrl_pkg;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_EXECI    = 4'd7,
      S_ALUWB    = 4'd8,
      S_BEQ      = 4'd9,
      S_JALRADR  = 4'd10,
      S_JAL      = 4'd11,
      S_MULDIV   = 4'd12,
      S_MULWB    = 4'd13,
      S_TRAP     = 4'd14
   } state_e;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;

   localparam logic [1:0] SRCB_RS2   = 2'b00;
   localparam logic [1:0] SRCB_IMM   = 2'b01;
   localparam logic [1:0] SRCB_FOUR  = 2'b10;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_MEMDATA   = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;
   localparam logic [1:0] RES_MULDIV    = 2'b11;

endpackage

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle RV32 main control FSM. Sequences one instruction through a
// shared memory port (req/ready), optionally waits on an iterative mul/div
// unit, and parks in a sticky trap on an unsupported opcode.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   FETCH    | read instr at PC, PC <= PC+4 and latch IR when mem_ready
//   DECODE   | compute branch target OldPC+imm, dispatch on opcode
//   MEMADR   | ALUOut <= rs1+imm for lw/sw
//   MEMREAD  | load access at ALUOut, hold until mem_ready
//   MEMWB    | rd <= load data
//   MEMWRITE | store access at ALUOut, write strobe with mem_ready
//   EXECR    | register-register ALU op
//   EXECI    | register-immediate ALU op
//   ALUWB    | rd <= ALUOut
//   BEQ      | compare rs1/rs2, conditional PC write to branch target
//   JALRADR  | ALUOut <= rs1+imm (jalr target)
//   JAL      | PC <= ALUOut, ALUOut <= OldPC+4
//   MULDIV   | start pulse on entry, wait for muldiv_done
//   MULWB    | rd <= mul/div result
//   TRAP     | illegal opcode seen, parked until reset
module multicycle_ctrl_fsm
   import rv_ctrl_pkg::*;
#(
   parameter bit ENABLE_M    = 1'b1,
   parameter bit ENABLE_JALR = 1'b1,
   parameter int STATE_W     = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] op,
   input  logic       funct7b0,
   input  logic       mem_ready,
   input  logic       muldiv_done,
   output logic       mem_req,
   output logic       AdrSrc,
   output logic       IRWrite,
   output logic       PCUpdate,
   output logic       Branch,
   output logic       RegWrite,
   output logic       MemWrite,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ALUOp,
   output logic [1:0] ResultSrc,
   output logic       muldiv_start,
   output logic       illegal
);

   logic [STATE_W-1:0] state_q;
   logic               illegal_q;
   logic               start_q;

   function automatic logic [STATE_W-1:0] enc(input state_e s);
      return STATE_W'(s);
   endfunction

   // State register with next-state decode; also tracks the MULDIV entry cycle and the sticky trap flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= enc(S_FETCH);
         illegal_q <= 1'b0;
         start_q   <= 1'b0;
      end else begin
         start_q <= 1'b0;
         case (state_q)
            enc(S_FETCH): begin
               if (mem_ready) state_q <= enc(S_DECODE);
            end
            enc(S_DECODE): begin
               case (op)
                  OP_LOAD, OP_STORE: state_q <= enc(S_MEMADR);
                  OP_RTYPE: begin
                     if (!funct7b0) begin
                        state_q <= enc(S_EXECR);
                     end else if (ENABLE_M) begin
                        state_q <= enc(S_MULDIV);
                        start_q <= 1'b1;
                     end else begin
                        state_q   <= enc(S_TRAP);
                        illegal_q <= 1'b1;
                     end
                  end
                  OP_ITYPE:  state_q <= enc(S_EXECI);
                  OP_BRANCH: state_q <= enc(S_BEQ);
                  OP_JAL:    state_q <= enc(S_JAL);
                  OP_JALR: begin
                     if (ENABLE_JALR) begin
                        state_q <= enc(S_JALRADR);
                     end else begin
                        state_q   <= enc(S_TRAP);
                        illegal_q <= 1'b1;
                     end
                  end
                  default: begin
                     state_q   <= enc(S_TRAP);
                     illegal_q <= 1'b1;
                  end
               endcase
            end
            enc(S_MEMADR): begin
               // op is stable from DECODE on, so it still selects load vs store here
               if (op == OP_LOAD)       state_q <= enc(S_MEMREAD);
               else if (op == OP_STORE) state_q <= enc(S_MEMWRITE);
               else                     state_q <= enc(S_FETCH);
            end
            enc(S_MEMREAD): begin
               if (mem_ready) state_q <= enc(S_MEMWB);
            end
            enc(S_MEMWB):    state_q <= enc(S_FETCH);
            enc(S_MEMWRITE): begin
               if (mem_ready) state_q <= enc(S_FETCH);
            end
            enc(S_EXECR):    state_q <= enc(S_ALUWB);
            enc(S_EXECI):    state_q <= enc(S_ALUWB);
            enc(S_ALUWB):    state_q <= enc(S_FETCH);
            enc(S_BEQ):      state_q <= enc(S_FETCH);
            enc(S_JALRADR):  state_q <= enc(S_JAL);
            enc(S_JAL):      state_q <= enc(S_ALUWB);
            enc(S_MULDIV): begin
               if (muldiv_done) state_q <= enc(S_MULWB);
            end
            enc(S_MULWB):    state_q <= enc(S_FETCH);
            enc(S_TRAP): begin
               state_q   <= enc(S_TRAP);
               illegal_q <= 1'b1;
            end
            default:         state_q <= enc(S_FETCH);
         endcase
      end
   end

   // Moore output decode; memory-completion strobes are qualified by mem_ready and everything is held quiet in reset.
   always_comb begin
      mem_req      = 1'b0;
      AdrSrc       = 1'b0;
      IRWrite      = 1'b0;
      PCUpdate     = 1'b0;
      Branch       = 1'b0;
      RegWrite     = 1'b0;
      MemWrite     = 1'b0;
      ALUSrcA      = SRCA_PC;
      ALUSrcB      = SRCB_RS2;
      ALUOp        = ALUOP_ADD;
      ResultSrc    = RES_ALUOUT;
      muldiv_start = 1'b0;
      if (!reset) begin
         case (state_q)
            enc(S_FETCH): begin
               mem_req   = 1'b1;
               ALUSrcB   = SRCB_FOUR;
               ResultSrc = RES_ALURESULT;
               IRWrite   = mem_ready;
               PCUpdate  = mem_ready;
            end
            enc(S_DECODE): begin
               ALUSrcA = SRCA_OLDPC;
               ALUSrcB = SRCB_IMM;
            end
            enc(S_MEMADR), enc(S_JALRADR): begin
               ALUSrcA = SRCA_RS1;
               ALUSrcB = SRCB_IMM;
            end
            enc(S_MEMREAD): begin
               mem_req = 1'b1;
               AdrSrc  = 1'b1;
            end
            enc(S_MEMWB): begin
               ResultSrc = RES_MEMDATA;
               RegWrite  = 1'b1;
            end
            enc(S_MEMWRITE): begin
               mem_req  = 1'b1;
               AdrSrc   = 1'b1;
               MemWrite = mem_ready;
            end
            enc(S_EXECR): begin
               ALUSrcA = SRCA_RS1;
               ALUSrcB = SRCB_RS2;
               ALUOp   = ALUOP_FUNCT;
            end
            enc(S_EXECI): begin
               ALUSrcA = SRCA_RS1;
               ALUSrcB = SRCB_IMM;
               ALUOp   = ALUOP_FUNCT;
            end
            enc(S_ALUWB): begin
               ResultSrc = RES_ALUOUT;
               RegWrite  = 1'b1;
            end
            enc(S_BEQ): begin
               ALUSrcA = SRCA_RS1;
               ALUSrcB = SRCB_RS2;
               ALUOp   = ALUOP_SUB;
               Branch  = 1'b1;
            end
            enc(S_JAL): begin
               ALUSrcA  = SRCA_OLDPC;
               ALUSrcB  = SRCB_FOUR;
               PCUpdate = 1'b1;
            end
            enc(S_MULDIV): begin
               muldiv_start = start_q;
            end
            enc(S_MULWB): begin
               ResultSrc = RES_MULDIV;
               RegWrite  = 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign illegal = illegal_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed bench for multicycle_ctrl_fsm: a vector table of per-cycle
// inputs and expected outputs/state, plus hand sequences for wait states,
// mul/div handshakes, trap and reset-abort cases.
module tb_multicycle_ctrl_fsm;
   import rv_ctrl_pkg::*;

   logic       clk = 1'b0;
   logic       reset;
   logic [6:0] op;
   logic       funct7b0;
   logic       mem_ready;
   logic       muldiv_done;
   logic       mem_req, AdrSrc, IRWrite, PCUpdate, Branch, RegWrite, MemWrite;
   logic [1:0] ALUSrcA, ALUSrcB, ALUOp, ResultSrc;
   logic       muldiv_start, illegal;

   multicycle_ctrl_fsm dut (
      .clk(clk), .reset(reset), .op(op), .funct7b0(funct7b0),
      .mem_ready(mem_ready), .muldiv_done(muldiv_done),
      .mem_req(mem_req), .AdrSrc(AdrSrc), .IRWrite(IRWrite), .PCUpdate(PCUpdate),
      .Branch(Branch), .RegWrite(RegWrite), .MemWrite(MemWrite),
      .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .ResultSrc(ResultSrc),
      .muldiv_start(muldiv_start), .illegal(illegal)
   );

   always #5 clk = ~clk;

   // {illegal, mem_req, AdrSrc, IRWrite, PCUpdate, Branch, RegWrite, MemWrite, A, B, ALUOp, ResultSrc, muldiv_start}
   logic [16:0] act;
   assign act = {illegal, mem_req, AdrSrc, IRWrite, PCUpdate, Branch, RegWrite, MemWrite,
                 ALUSrcA, ALUSrcB, ALUOp, ResultSrc, muldiv_start};

   localparam logic [16:0] X_ZERO    = 17'b0;
   localparam logic [16:0] X_FETCH_R = {1'b0, 1'b1,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0, 2'b00,2'b10,2'b00,2'b10, 1'b0};
   localparam logic [16:0] X_FETCH_W = {1'b0, 1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'b00,2'b10,2'b00,2'b10, 1'b0};
   localparam logic [16:0] X_DECODE  = {1'b0, 7'b0, 2'b01,2'b01,2'b00,2'b00, 1'b0};
   localparam logic [16:0] X_ADR     = {1'b0, 7'b0, 2'b10,2'b01,2'b00,2'b00, 1'b0};
   localparam logic [16:0] X_MEMACC  = {1'b0, 1'b1,1'b1,5'b0, 8'b0, 1'b0};
   localparam logic [16:0] X_MEMWB   = {1'b0, 5'b0,1'b1,1'b0, 2'b00,2'b00,2'b00,2'b01, 1'b0};
   localparam logic [16:0] X_MEMWR_R = {1'b0, 1'b1,1'b1,4'b0,1'b1, 8'b0, 1'b0};
   localparam logic [16:0] X_EXECR   = {1'b0, 7'b0, 2'b10,2'b00,2'b10,2'b00, 1'b0};
   localparam logic [16:0] X_EXECI   = {1'b0, 7'b0, 2'b10,2'b01,2'b10,2'b00, 1'b0};
   localparam logic [16:0] X_ALUWB   = {1'b0, 5'b0,1'b1,1'b0, 8'b0, 1'b0};
   localparam logic [16:0] X_BEQ     = {1'b0, 4'b0,1'b1,2'b0, 2'b10,2'b00,2'b01,2'b00, 1'b0};
   localparam logic [16:0] X_JAL     = {1'b0, 3'b0,1'b1,3'b0, 2'b01,2'b10,2'b00,2'b00, 1'b0};
   localparam logic [16:0] X_MULS    = {1'b0, 7'b0, 8'b0, 1'b1};
   localparam logic [16:0] X_MULWB   = {1'b0, 5'b0,1'b1,1'b0, 2'b00,2'b00,2'b00,2'b11, 1'b0};
   localparam logic [16:0] X_TRAP    = {1'b1, 16'b0};

   localparam logic [6:0] OP_ECALL = 7'b1110011;

   typedef struct {
      logic [6:0]  op;
      logic        f7;
      logic        mr;
      logic        md;
      logic [16:0] exp;
      state_e      st;
   } vec_t;

   vec_t vecs[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   function automatic void add(input logic [6:0] o, input logic f, input logic r, input logic d,
                               input logic [16:0] e, input state_e s);
      vec_t v;
      v.op = o; v.f7 = f; v.mr = r; v.md = d; v.exp = e; v.st = s;
      vecs.push_back(v);
   endfunction

   task automatic drive(input logic [6:0] o, input logic f, input logic r, input logic d);
      op = o; funct7b0 = f; mem_ready = r; muldiv_done = d;
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic chk(input string name, input logic [16:0] exp, input state_e st);
      #1;
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: outputs got %b want %b", name, act, exp);
      end
      n_checks++;
      if (dut.state_q !== 4'(st)) begin
         n_fail++;
         $display("FAIL %s: state got %0d want %0d", name, dut.state_q, 4'(st));
      end
   endtask

   initial begin
      // add, with a stray muldiv_done during ALUWB
      add(OP_RTYPE,0,1,0, X_FETCH_R, S_FETCH);
      add(OP_RTYPE,0,1,0, X_DECODE,  S_DECODE);
      add(OP_RTYPE,0,1,0, X_EXECR,   S_EXECR);
      add(OP_RTYPE,0,1,1, X_ALUWB,   S_ALUWB);
      // fetch wait then addi
      add(OP_ITYPE,0,0,0, X_FETCH_W, S_FETCH);
      add(OP_ITYPE,0,1,0, X_FETCH_R, S_FETCH);
      add(OP_ITYPE,0,1,0, X_DECODE,  S_DECODE);
      add(OP_ITYPE,0,1,0, X_EXECI,   S_EXECI);
      add(OP_ITYPE,0,1,0, X_ALUWB,   S_ALUWB);
      // beq: 3 cycles
      add(OP_BRANCH,0,1,0, X_FETCH_R, S_FETCH);
      add(OP_BRANCH,0,1,0, X_DECODE,  S_DECODE);
      add(OP_BRANCH,0,1,0, X_BEQ,     S_BEQ);
      // lw zero-wait: 5 cycles
      add(OP_LOAD,0,1,0, X_FETCH_R, S_FETCH);
      add(OP_LOAD,0,1,0, X_DECODE,  S_DECODE);
      add(OP_LOAD,0,1,0, X_ADR,     S_MEMADR);
      add(OP_LOAD,0,1,0, X_MEMACC,  S_MEMREAD);
      add(OP_LOAD,0,1,0, X_MEMWB,   S_MEMWB);
      // sw zero-wait: 4 cycles
      add(OP_STORE,0,1,0, X_FETCH_R, S_FETCH);
      add(OP_STORE,0,1,0, X_DECODE,  S_DECODE);
      add(OP_STORE,0,1,0, X_ADR,     S_MEMADR);
      add(OP_STORE,0,1,0, X_MEMWR_R, S_MEMWRITE);
      // jal: 4 cycles
      add(OP_JAL,0,1,0, X_FETCH_R, S_FETCH);
      add(OP_JAL,0,1,0, X_DECODE,  S_DECODE);
      add(OP_JAL,0,1,0, X_JAL,     S_JAL);
      add(OP_JAL,0,1,0, X_ALUWB,   S_ALUWB);
      // jalr: 5 cycles
      add(OP_JALR,0,1,0, X_FETCH_R, S_FETCH);
      add(OP_JALR,0,1,0, X_DECODE,  S_DECODE);
      add(OP_JALR,0,1,0, X_ADR,     S_JALRADR);
      add(OP_JALR,0,1,0, X_JAL,     S_JAL);
      add(OP_JALR,0,1,0, X_ALUWB,   S_ALUWB);

      reset = 1'b1;
      drive(7'b0, 1'b0, 1'b1, 1'b0);
      tick();
      tick();
      chk("reset", X_ZERO, S_FETCH);
      reset = 1'b0;

      foreach (vecs[i]) begin
         drive(vecs[i].op, vecs[i].f7, vecs[i].mr, vecs[i].md);
         chk($sformatf("vec%0d", i), vecs[i].exp, vecs[i].st);
         tick();
      end

      // lw with two wait cycles in MEMREAD: MEMWB lands on cycle 7
      drive(OP_LOAD,0,1,0); chk("lw_fetch",  X_FETCH_R, S_FETCH);   tick();
      chk("lw_dec",   X_DECODE, S_DECODE);  tick();
      chk("lw_adr",   X_ADR,    S_MEMADR);  tick();
      drive(OP_LOAD,0,0,0); chk("lw_wait1", X_MEMACC, S_MEMREAD); tick();
      chk("lw_wait2", X_MEMACC, S_MEMREAD); tick();
      drive(OP_LOAD,0,1,0); chk("lw_rdy",   X_MEMACC, S_MEMREAD); tick();
      chk("lw_wb",    X_MEMWB,  S_MEMWB);   tick();
      chk("lw_next",  X_FETCH_R, S_FETCH);  tick();
      chk("lw_next_dec", X_DECODE, S_DECODE); tick();
      chk("lw_next_adr", X_ADR, S_MEMADR); tick();
      chk("lw_next_rd",  X_MEMACC, S_MEMREAD); tick();
      chk("lw_next_wb",  X_MEMWB, S_MEMWB); tick();

      // sw with one wait cycle: MemWrite only in the ready cycle
      drive(OP_STORE,0,1,0); chk("sw_fetch", X_FETCH_R, S_FETCH); tick();
      chk("sw_dec", X_DECODE, S_DECODE); tick();
      chk("sw_adr", X_ADR,    S_MEMADR); tick();
      drive(OP_STORE,0,0,0); chk("sw_wait", X_MEMACC, S_MEMWRITE); tick();
      drive(OP_STORE,0,1,0); chk("sw_rdy",  X_MEMWR_R, S_MEMWRITE); tick();
      chk("sw_done", X_FETCH_R, S_FETCH); tick();
      chk("sw_after_dec", X_DECODE, S_DECODE); tick();
      chk("sw_after_adr", X_ADR, S_MEMADR); tick();
      chk("sw_after_wr", X_MEMWR_R, S_MEMWRITE); tick();

      // mul, done three cycles after the start pulse
      drive(OP_RTYPE,1,1,0); chk("mul_fetch", X_FETCH_R, S_FETCH); tick();
      chk("mul_dec",   X_DECODE, S_DECODE); tick();
      chk("mul_start", X_MULS,   S_MULDIV); tick();
      chk("mul_wait1", X_ZERO,   S_MULDIV); tick();
      chk("mul_wait2", X_ZERO,   S_MULDIV); tick();
      drive(OP_RTYPE,1,1,1); chk("mul_done", X_ZERO, S_MULDIV); tick();
      drive(OP_RTYPE,1,1,0); chk("mul_wb", X_MULWB, S_MULWB); tick();
      chk("mul_next", X_FETCH_R, S_FETCH); tick();

      // mul with done on the start cycle itself
      chk("mul0_dec", X_DECODE, S_DECODE); tick();
      drive(OP_RTYPE,1,1,1); chk("mul0_start", X_MULS, S_MULDIV); tick();
      drive(OP_RTYPE,1,1,0); chk("mul0_wb", X_MULWB, S_MULWB); tick();
      chk("mul0_next", X_FETCH_R, S_FETCH); tick();

      // illegal opcode: trap is sticky and silent regardless of inputs
      drive(OP_ECALL,0,1,0); chk("trap_dec", X_DECODE, S_DECODE); tick();
      for (int i = 0; i < 20; i++) begin
         drive(OP_ECALL, 1'b0, 1'(i % 2), 1'b1);
         chk($sformatf("trap%0d", i), X_TRAP, S_TRAP);
         tick();
      end
      reset = 1'b1;
      tick();
      chk("trap_rst", X_ZERO, S_FETCH);
      reset = 1'b0;
      drive(OP_BRANCH,0,1,0); chk("trap_rel", X_FETCH_R, S_FETCH); tick();
      chk("trap_rel_dec", X_DECODE, S_DECODE); tick();
      chk("trap_rel_beq", X_BEQ, S_BEQ); tick();

      // jalr aborted by reset while in JALRADR
      drive(OP_JALR,0,1,0); chk("jr_fetch", X_FETCH_R, S_FETCH); tick();
      chk("jr_dec", X_DECODE, S_DECODE); tick();
      chk("jr_adr", X_ADR,    S_JALRADR);
      reset = 1'b1;
      chk("jr_rst_hold", X_ZERO, S_JALRADR); tick();
      chk("jr_rst_fetch", X_ZERO, S_FETCH); tick();
      chk("jr_rst_fetch2", X_ZERO, S_FETCH);
      reset = 1'b0;
      drive(OP_RTYPE,0,1,0); chk("jr_rel", X_FETCH_R, S_FETCH); tick();
      chk("jr_rel_dec", X_DECODE, S_DECODE); tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
